// File: rtl/score_tracker.sv
// Frame-sampled score counter with collision freeze, high score and a sequential
// double-dabble BCD copy. Optional high score: define SCORE_TRACKER_HIGH_SCORE_EN.
module score_tracker #(
  parameter int unsigned SCORE_MAX  = 255,
  parameter int unsigned HOLD_TICKS = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_tick,
  input  logic        i_move,
  input  logic        i_collision,
  input  logic        i_restart,
  output logic [7:0]  o_score,
  output logic [7:0]  o_high_score,
  output logic [11:0] o_bcd,
  output logic        o_bcd_busy,
  output logic        o_game_over
);

  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_TICKS - 1);
  localparam logic [7:0] SCORE_TOP   = 8'(SCORE_MAX);
  localparam logic [3:0] LAST_ITER   = 4'd8;

  state_t      state_q, state_d;
  logic [7:0]  score_q;
  logic [7:0]  hold_q, hold_d;
  logic        prev_q, prev_d;
  logic        armed_q, armed_d;
  logic        inc_req, inc_go, restart_go, collision_go;

  logic        conv_req_q;
  logic [19:0] shift_q;
  logic [3:0]  iter_q;

  // A hold run only exists after a real press; a button held through reset or
  // restart must never reach the zero-counter auto-increment branch.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    hold_d       = hold_q;
    prev_d       = prev_q;
    armed_d      = armed_q;
    inc_req      = 1'b0;
    restart_go   = 1'b0;
    collision_go = 1'b0;
    case (state_q)
      PLAY: begin
        if (i_collision) begin
          collision_go = 1'b1;
          state_d      = OVER;
        end else if (i_frame_tick) begin
          prev_d = i_move;
          if (!i_move) begin
            hold_d  = 8'd0;
            armed_d = 1'b0;
          end else if (!prev_q) begin
            inc_req = 1'b1;
            hold_d  = HOLD_RELOAD;
            armed_d = 1'b1;
          end else if (armed_q) begin
            if (hold_q != 8'd0) begin
              hold_d = hold_q - 8'd1;
            end else begin
              inc_req = 1'b1;
              hold_d  = HOLD_RELOAD;
            end
          end
        end
      end
      OVER: begin
        if (i_restart) begin
          restart_go = 1'b1;
          state_d    = PLAY;
          hold_d     = 8'd0;
          prev_d     = 1'b1;
          armed_d    = 1'b0;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  assign inc_go = inc_req && (score_q != SCORE_TOP);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= PLAY;
      score_q <= 8'd0;
      hold_q  <= 8'd0;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      if (restart_go)  score_q <= 8'd0;
      else if (inc_go) score_q <= score_q + 8'd1;
    end
  end

`ifdef SCORE_TRACKER_HIGH_SCORE_EN
  logic [7:0] high_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      high_q <= 8'd0;
    end else if (collision_go && (score_q > high_q)) begin
      high_q <= score_q;
    end
  end
  assign o_high_score = high_q;
`else
  assign o_high_score = 8'd0;
`endif

  // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dabble(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (r[8 + 4*i +: 4] >= 4'd5) r[8 + 4*i +: 4] = r[8 + 4*i +: 4] + 4'd3;
    end
    return {r[18:0], 1'b0};
  endfunction

  // A pending request always wins over the running conversion, which aborts it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      conv_req_q <= 1'b0;
      shift_q    <= 20'd0;
      iter_q     <= 4'd0;
      o_bcd      <= 12'd0;
      o_bcd_busy <= 1'b0;
    end else begin
      conv_req_q <= inc_go || restart_go;
      if (conv_req_q) begin
        shift_q    <= {12'd0, score_q};
        iter_q     <= 4'd0;
        o_bcd_busy <= 1'b1;
      end else if (o_bcd_busy) begin
        if (iter_q == LAST_ITER) begin
          o_bcd      <= shift_q[19:8];
          o_bcd_busy <= 1'b0;
        end else begin
          shift_q <= dabble(shift_q);
          iter_q  <= iter_q + 4'd1;
        end
      end
    end
  end

  assign o_score     = score_q;
  assign o_game_over = (state_q == OVER);

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: directed scenarios plus random stimulus
// against a frame-level game model and a "latest change + 10 cycles" BCD model.
module tb_score_tracker;

  localparam int SM = 255;
  localparam int HT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        move = 1'b0;
  logic        collision = 1'b0;
  logic        restart = 1'b0;
  logic [7:0]  score;
  logic [7:0]  high_score;
  logic [11:0] bcd;
  logic        bcd_busy;
  logic        game_over;

  score_tracker #(.SCORE_MAX(SM), .HOLD_TICKS(HT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_frame_tick (frame_tick),
    .i_move       (move),
    .i_collision  (collision),
    .i_restart    (restart),
    .o_score      (score),
    .o_high_score (high_score),
    .o_bcd        (bcd),
    .o_bcd_busy   (bcd_busy),
    .o_game_over  (game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_score, m_high, m_run, n, last_change, change_val;
  bit          m_over, m_prev, exp_busy;
  logic [11:0] exp_bcd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int exp_high();
`ifdef SCORE_TRACKER_HIGH_SCORE_EN
    return m_high;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_score = 0; m_high = 0; m_over = 0; m_prev = 1; m_run = -1;
    last_change = -1000; change_val = 0; exp_bcd = 12'h000; exp_busy = 0;
  endtask

  // Effect of one clock edge given the inputs sampled there.
  task automatic model_edge(input bit t, input bit mv, input bit col, input bit rs, input bit r);
    int  gap;
    bit  changed;
    n++;
    if (r) begin
      model_reset();
      return;
    end
    gap = n - last_change;
    exp_busy = (gap >= 1) && (gap <= 9);
    if (gap == 10) exp_bcd = to_bcd(change_val);
    changed = 0;
    if (!m_over) begin
      if (col) begin
        m_over = 1;
        if (m_score > m_high) m_high = m_score;
      end else if (t) begin
        bit want;
        want = 0;
        if (mv && !m_prev) begin
          m_run = 0;
          want  = 1;
        end else if (mv && m_run >= 0) begin
          m_run++;
          want = (m_run % HT) == 0;
        end else if (!mv) begin
          m_run = -1;
        end
        m_prev = mv;
        if (want && m_score < SM) begin
          m_score++;
          changed = 1;
        end
      end
    end else if (rs) begin
      m_over = 0; m_score = 0; m_prev = 1; m_run = -1;
      changed = 1;
    end
    if (changed) begin
      last_change = n;
      change_val  = m_score;
    end
  endtask

  task automatic step(input bit t, input bit mv, input bit col, input bit rs, input bit r);
    frame_tick = t; move = mv; collision = col; restart = rs; rst = r;
    @(posedge clk);
    model_edge(t, mv, col, rs, r);
    #1;
    check("score", score, m_score);
    check("high_score", high_score, exp_high());
    check("game_over", game_over, m_over);
    check("bcd_busy", bcd_busy, exp_busy);
    check("bcd", bcd, exp_bcd);
  endtask

  // One frame: a tick cycle followed by one idle cycle.
  task automatic frame(input bit mv);
    step(1, mv, 0, 0, 0);
    step(0, mv, 0, 0, 0);
  endtask

  task automatic idle(input int cycles, input bit mv);
    for (int i = 0; i < cycles; i++) step(0, mv, 0, 0, 0);
  endtask

  initial begin
    bit rmove;
    n = 0;
    model_reset();

    // Reset, three idle frames, then one press
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("reset_score", score, 8'd0);
    check("reset_bcd", bcd, 12'h000);
    for (int i = 0; i < 3; i++) frame(0);
    frame(1);
    frame(0);
    idle(10, 0);
    check("t1_score", score, 8'd1);
    check("t1_bcd", bcd, 12'h001);

    // Held for 17 ticks from a press: three increments
    for (int i = 0; i < 17; i++) frame(1);
    frame(0);
    check("hold_score", score, 8'd4);

    // Presses up to 37, then collision with a fresh press on the same tick
    while (m_score < 37) begin
      frame(1);
      frame(0);
    end
    step(1, 1, 1, 0, 0);
    check("col_score", score, 8'd37);
    check("col_over", game_over, 1'b1);
`ifdef SCORE_TRACKER_HIGH_SCORE_EN
    check("col_high", high_score, 8'd37);
`else
    check("col_high", high_score, 8'd0);
`endif
    idle(2, 0);
    frame(1); frame(0); frame(1);
    check("over_frozen", score, 8'd37);

    // Restart with the button held: no score until release and press
    step(0, 1, 0, 1, 0);
    idle(11, 1);
    check("rs_score", score, 8'd0);
    check("rs_bcd", bcd, 12'h000);
    check("rs_over", game_over, 1'b0);
    frame(1);
    check("rs_held", score, 8'd0);
    frame(0);
    frame(1);
    idle(11, 1);
    check("rs_press", score, 8'd1);
    check("rs_press_bcd", bcd, 12'h001);

    // Saturation at SCORE_MAX
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < SM + 2; i++) begin
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
    end
    idle(12, 0);
    check("sat_score", score, 8'd255);
    check("sat_bcd", bcd, 12'h255);
    check("sat_busy", bcd_busy, 1'b0);

    // Two changes four cycles apart: first conversion aborted
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    idle(9, 1);
    check("abort_stale", bcd, 12'h000);
    idle(1, 1);
    check("abort_bcd", bcd, 12'h002);

    // Random stimulus against the model
    rmove = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) rmove = ~rmove;
      step($urandom_range(0, 2) == 0, rmove, $urandom_range(0, 59) == 0,
           $urandom_range(0, 14) == 0, $urandom_range(0, 799) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
